// File: rtl/conv_window_gen_pkg.sv
// Shared constants, state encoding and helpers for the 3x3 convolution window generator.
package conv_window_gen_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int KERNEL        = 3;
  localparam int MAC_IN_NUM    = KERNEL * KERNEL;
  localparam int IMG_WIDTH_MAX = 224;
  localparam int DIM_BITS      = 8;

  typedef logic [DIM_BITS-1:0]   dim_t;
  typedef logic [DATA_WIDTH-1:0] pix_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } conv_state_t;

  // Flat element index of window position (row r, column c); row 0 is the oldest line.
  function automatic int win_idx(input int r, input int c);
    return r * KERNEL + c;
  endfunction

  function automatic logic cfg_legal(input dim_t w, input dim_t h);
    return (w >= dim_t'(KERNEL)) && (int'(w) <= IMG_WIDTH_MAX) && (h >= dim_t'(KERNEL));
  endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image line of storage: simple dual-port RAM with a registered (1-cycle) read port.
module conv_window_gen_line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter int DEPTH     = IMG_WIDTH_MAX,
  parameter int WIDTH     = DATA_WIDTH,
  parameter int ADDR_BITS = DIM_BITS
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; every location is rewritten before a window can use it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 sliding windows (stride 1, no padding) for the NPU MAC input.
// Two cascaded line buffers supply the two older rows; fixed 2-cycle pixel-to-window latency.
module conv_window_gen
  import conv_window_gen_pkg::*;
(
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             frame_start,
  input  logic [DIM_BITS-1:0]              cfg_img_w,
  input  logic [DIM_BITS-1:0]              cfg_img_h,
  input  logic [DATA_WIDTH-1:0]            pix_in,
  input  logic                             pix_valid_in,
  output logic [MAC_IN_NUM*DATA_WIDTH-1:0] MAC_data_in,
  output logic                             MAC_data_valid_in,
  output logic                             frame_done,
  output logic                             cfg_err,
  output logic                             busy
);

  // state     | meaning
  // ST_IDLE   | no frame active; pixels are dropped and flagged
  // ST_FILL   | first two rows of a frame being written into the line buffers
  // ST_STREAM | row 2 onward; windows are produced

  conv_state_t state;
  dim_t        img_w, img_h;
  dim_t        x_cnt, y_cnt;

  logic cfg_ok, start_legal, start_bad, abort, accept;
  dim_t cur_w, cur_h, acc_x, acc_y;
  logic row_end, last_pix;

  logic s1_valid, s1_last;
  pix_t s1_pix;
  dim_t s1_x, s1_y;
  pix_t lb0_rd, lb1_rd;
  pix_t win [KERNEL][KERNEL];

  // A legal frame_start restarts the counters in the same cycle, so a pixel
  // arriving with it is taken as pixel (0,0) of the new frame.
  always_comb begin
    cfg_ok      = cfg_legal(cfg_img_w, cfg_img_h);
    start_legal = frame_start && cfg_ok;
    start_bad   = frame_start && !cfg_ok;
    abort       = frame_start && (state != ST_IDLE);
    accept      = pix_valid_in && (start_legal || (!frame_start && (state != ST_IDLE)));
    cur_w       = start_legal ? cfg_img_w : img_w;
    cur_h       = start_legal ? cfg_img_h : img_h;
    acc_x       = start_legal ? '0 : x_cnt;
    acc_y       = start_legal ? '0 : y_cnt;
    row_end     = (acc_x == cur_w - dim_t'(1));
    last_pix    = row_end && (acc_y == cur_h - dim_t'(1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      cfg_err <= 1'b0;
      img_w   <= '0;
      img_h   <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else if (start_bad) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      cfg_err <= 1'b1;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      if (start_legal) begin
        img_w   <= cfg_img_w;
        img_h   <= cfg_img_h;
        cfg_err <= 1'b0;
        state   <= ST_FILL;
        busy    <= 1'b1;
        x_cnt   <= '0;
        y_cnt   <= '0;
      end else if (pix_valid_in && (state == ST_IDLE)) begin
        cfg_err <= 1'b1;
      end

      if (accept) begin
        if (row_end) begin
          x_cnt <= '0;
          y_cnt <= acc_y + dim_t'(1);
        end else begin
          x_cnt <= acc_x + dim_t'(1);
          y_cnt <= acc_y;
        end
        if (last_pix) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else if ((acc_y == dim_t'(KERNEL - 1)) && (acc_x == '0)) begin
          state <= ST_STREAM;
          busy  <= 1'b1;
        end
      end
    end
  end

  // Read of column x overlaps the write of column x-1 from the previous pixel;
  // with W >= 3 the two addresses never coincide.
  conv_window_gen_line_buffer u_lb0 (
    .clk     (clk),
    .wr_en   (s1_valid),
    .wr_addr (s1_x),
    .wr_data (s1_pix),
    .rd_en   (accept),
    .rd_addr (acc_x),
    .rd_data (lb0_rd)
  );

  conv_window_gen_line_buffer u_lb1 (
    .clk     (clk),
    .wr_en   (s1_valid),
    .wr_addr (s1_x),
    .wr_data (lb0_rd),
    .rd_en   (accept),
    .rd_addr (acc_x),
    .rd_data (lb1_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid          <= 1'b0;
      s1_last           <= 1'b0;
      s1_pix            <= '0;
      s1_x              <= '0;
      s1_y              <= '0;
      MAC_data_valid_in <= 1'b0;
      frame_done        <= 1'b0;
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pix  <= pix_in;
        s1_x    <= acc_x;
        s1_y    <= acc_y;
        s1_last <= last_pix;
      end

      // An abort suppresses the window still in flight from the old frame.
      MAC_data_valid_in <= s1_valid && !abort &&
                           (s1_x >= dim_t'(KERNEL - 1)) && (s1_y >= dim_t'(KERNEL - 1));
      frame_done        <= s1_valid && !abort && s1_last;

      if (s1_valid) begin
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL - 1; c++) begin
            win[r][c] <= win[r][c+1];
          end
        end
        win[0][KERNEL-1] <= lb1_rd;
        win[1][KERNEL-1] <= lb0_rd;
        win[2][KERNEL-1] <= s1_pix;
      end
    end
  end

  always_comb begin
    MAC_data_in = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        MAC_data_in[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: config-legality vector table plus frame-level sequences
// checked against a pixel-array reference of the expected windows and their arrival times.
module tb_conv_window_gen;

  localparam int          CLK_HALF = 5;
  localparam longint      WIN_LAT  = 15;
  localparam logic [71:0] T1_FIRST = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
  localparam logic [71:0] T1_LAST  = {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6};
  localparam int          NV       = 13;

  logic        clk = 1'b0;
  logic        rstn;
  logic        frame_start;
  logic [7:0]  cfg_img_w, cfg_img_h;
  logic [7:0]  pix_in;
  logic        pix_valid_in;
  logic [71:0] MAC_data_in;
  logic        MAC_data_valid_in;
  logic        frame_done;
  logic        cfg_err;
  logic        busy;

  conv_window_gen dut (
    .clk               (clk),
    .rstn              (rstn),
    .frame_start       (frame_start),
    .cfg_img_w         (cfg_img_w),
    .cfg_img_h         (cfg_img_h),
    .pix_in            (pix_in),
    .pix_valid_in      (pix_valid_in),
    .MAC_data_in       (MAC_data_in),
    .MAC_data_valid_in (MAC_data_valid_in),
    .frame_done        (frame_done),
    .cfg_err           (cfg_err),
    .busy              (busy)
  );

  always #CLK_HALF clk = ~clk;

  typedef struct {
    longint      t;
    logic [71:0] d;
    logic        v;
    logic        fd;
  } win_rec_t;

  typedef struct {
    logic       fs;
    logic       pv;
    logic [7:0] w;
    logic [7:0] h;
    logic       exp_err;
    logic       exp_busy;
  } cfg_vec_t;

  win_rec_t got_q[$];
  win_rec_t exp_q[$];
  win_rec_t mon_rec;
  cfg_vec_t cfg_tbl[NV];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_x, m_y, m_w, m_h;
  bit         m_act = 1'b0;
  logic [7:0] img [8][224];
  longint     t_edge;
  longint     t_p11;
  logic [71:0] wv;
  int         picks[3];

  always @(negedge clk) begin
    if (MAC_data_valid_in || frame_done) begin
      mon_rec.t  = longint'($time);
      mon_rec.d  = MAC_data_in;
      mon_rec.v  = MAC_data_valid_in;
      mon_rec.fd = frame_done;
      got_q.push_back(mon_rec);
    end
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, update the reference model at the sampling edge.
  task automatic step(input logic fs, input logic pv, input logic [7:0] px);
    win_rec_t    rec;
    logic [71:0] wd;
    bit          last;
    frame_start  = fs;
    pix_valid_in = pv;
    pix_in       = px;
    @(posedge clk);
    t_edge = longint'($time);
    if (fs) begin
      m_act = (cfg_img_w >= 8'd3) && (cfg_img_w <= 8'd224) && (cfg_img_h >= 8'd3);
      m_x   = 0;
      m_y   = 0;
      m_w   = int'(cfg_img_w);
      m_h   = int'(cfg_img_h);
    end
    if (pv && m_act) begin
      img[m_y][m_x] = px;
      last = (m_x == m_w - 1) && (m_y == m_h - 1);
      if (m_x >= 2 && m_y >= 2) begin
        wd = '0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            wd[(r*3+c)*8 +: 8] = img[m_y-2+r][m_x-2+c];
          end
        end
        rec.t  = t_edge + WIN_LAT;
        rec.d  = wd;
        rec.v  = 1'b1;
        rec.fd = last;
        exp_q.push_back(rec);
      end
      if (m_x == m_w - 1) begin
        m_x = 0;
        m_y++;
      end else begin
        m_x++;
      end
      if (last) m_act = 1'b0;
    end
    #1;
    frame_start  = 1'b0;
    pix_valid_in = 1'b0;
    pix_in       = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic cmp_queues(input string nm);
    int n;
    chk({nm, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", nm, i), got_q[i].d, exp_q[i].d);
      chk($sformatf("%s_time%0d", nm, i), 72'(got_q[i].t), 72'(exp_q[i].t));
      chk($sformatf("%s_vdone%0d", nm, i), 72'({got_q[i].v, got_q[i].fd}),
          72'({exp_q[i].v, exp_q[i].fd}));
    end
  endtask

  task automatic run_4x4(input string nm);
    clear_q();
    cfg_img_w = 8'd4;
    cfg_img_h = 8'd4;
    step(1'b1, 1'b0, 8'd0);
    for (int p = 1; p <= 16; p++) begin
      step(1'b0, 1'b1, 8'(p));
      if (p == 11) t_p11 = t_edge;
    end
    idle(4);
    chk({nm, "_first_win"}, got_q[0].d, T1_FIRST);
    chk({nm, "_first_time"}, 72'(got_q[0].t), 72'(t_p11 + WIN_LAT));
    chk({nm, "_last_win"}, got_q[3].d, T1_LAST);
    chk({nm, "_last_done"}, 72'(got_q[3].fd), 72'(1));
    cmp_queues(nm);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_tbl[0]  = '{1'b1, 1'b0, 8'd2,   8'd4,   1'b1, 1'b0};
    cfg_tbl[1]  = '{1'b0, 1'b1, 8'd2,   8'd4,   1'b1, 1'b0};
    cfg_tbl[2]  = '{1'b1, 1'b0, 8'd4,   8'd4,   1'b0, 1'b1};
    cfg_tbl[3]  = '{1'b1, 1'b0, 8'd225, 8'd3,   1'b1, 1'b0};
    cfg_tbl[4]  = '{1'b1, 1'b0, 8'd224, 8'd3,   1'b0, 1'b1};
    cfg_tbl[5]  = '{1'b1, 1'b0, 8'd4,   8'd2,   1'b1, 1'b0};
    cfg_tbl[6]  = '{1'b0, 1'b1, 8'd4,   8'd2,   1'b1, 1'b0};
    cfg_tbl[7]  = '{1'b1, 1'b0, 8'd3,   8'd255, 1'b0, 1'b1};
    cfg_tbl[8]  = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0};
    cfg_tbl[9]  = '{1'b1, 1'b0, 8'd3,   8'd3,   1'b0, 1'b1};
    cfg_tbl[10] = '{1'b1, 1'b0, 8'd255, 8'd5,   1'b1, 1'b0};
    cfg_tbl[11] = '{1'b0, 1'b1, 8'd255, 8'd5,   1'b1, 1'b0};
    cfg_tbl[12] = '{1'b1, 1'b0, 8'd3,   8'd3,   1'b0, 1'b1};
    picks = '{0, 100, 221};

    rstn         = 1'b0;
    frame_start  = 1'b0;
    pix_valid_in = 1'b0;
    pix_in       = '0;
    cfg_img_w    = '0;
    cfg_img_h    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", 72'({MAC_data_valid_in, frame_done, cfg_err, busy}), 72'(0));
    chk("reset_data", MAC_data_in, 72'(0));
    rstn = 1'b1;

    // Configuration legality and stray-pixel table
    clear_q();
    for (int i = 0; i < NV; i++) begin
      cfg_img_w = cfg_tbl[i].w;
      cfg_img_h = cfg_tbl[i].h;
      step(cfg_tbl[i].fs, cfg_tbl[i].pv, 8'h5A);
      chk($sformatf("cfg%0d_err", i), 72'(cfg_err), 72'(cfg_tbl[i].exp_err));
      chk($sformatf("cfg%0d_busy", i), 72'(busy), 72'(cfg_tbl[i].exp_busy));
    end
    idle(3);
    chk("cfg_no_windows", 72'(got_q.size()), 72'(0));

    // 4x4 back-to-back
    run_4x4("t1");
    chk("t1_idle_busy", 72'(busy), 72'(0));

    // Stray pixel after a clean frame
    step(1'b0, 1'b1, 8'hAA);
    chk("stray_err", 72'(cfg_err), 72'(1));
    chk("stray_busy", 72'(busy), 72'(0));

    // 4x4 with pix_valid_in toggling
    clear_q();
    cfg_img_w = 8'd4;
    cfg_img_h = 8'd4;
    step(1'b1, 1'b0, 8'd0);
    chk("t2_err_cleared", 72'(cfg_err), 72'(0));
    for (int p = 1; p <= 16; p++) begin
      step(1'b0, 1'b1, 8'(p));
      step(1'b0, 1'b0, 8'd0);
    end
    idle(4);
    chk("t2_first_win", got_q[0].d, T1_FIRST);
    chk("t2_last_win", got_q[3].d, T1_LAST);
    cmp_queues("t2");

    // Abort a 5x5 frame after 12 pixels; restart with a 4x4 frame whose first pixel rides the start
    clear_q();
    cfg_img_w = 8'd5;
    cfg_img_h = 8'd5;
    step(1'b1, 1'b0, 8'd0);
    for (int p = 1; p <= 12; p++) step(1'b0, 1'b1, 8'(p + 100));
    cfg_img_w = 8'd4;
    cfg_img_h = 8'd4;
    step(1'b1, 1'b1, 8'd1);
    for (int p = 2; p <= 16; p++) step(1'b0, 1'b1, 8'(p));
    idle(4);
    chk("t4_first_win", got_q[0].d, T1_FIRST);
    chk("t4_last_win", got_q[3].d, T1_LAST);
    cmp_queues("t4");

    // Reset in the middle of a 4x4 frame
    clear_q();
    cfg_img_w = 8'd4;
    cfg_img_h = 8'd4;
    step(1'b1, 1'b0, 8'd0);
    for (int p = 1; p <= 10; p++) step(1'b0, 1'b1, 8'(p));
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rst_flags", 72'({MAC_data_valid_in, frame_done, cfg_err, busy}), 72'(0));
    chk("t5_rst_data", MAC_data_in, 72'(0));
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    m_act = 1'b0;
    idle(3);
    chk("t5_no_windows", 72'(got_q.size()), 72'(0));
    run_4x4("t5");

    // Maximum width, three rows, ramp data
    clear_q();
    cfg_img_w = 8'd224;
    cfg_img_h = 8'd3;
    step(1'b1, 1'b0, 8'd0);
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 224; x++) step(1'b0, 1'b1, 8'(y * 224 + x));
    end
    idle(4);
    chk("t6_count_222", 72'(got_q.size()), 72'(222));
    for (int i = 0; i < 3; i++) begin
      wv = got_q[picks[i]].d;
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("t6_top_n%0d_c%0d", picks[i], c), 72'(wv[c*8 +: 8]), 72'(picks[i] + c));
      end
    end
    chk("t6_last_done", 72'(got_q[221].fd), 72'(1));
    cmp_queues("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
